// File: rtl/tb_sync_ctrl.sv
// rtl/tb_sync_ctrl.sv - staggered per-channel DUT reset sequencer with run watchdog
// Optional TB_SYNC_CTRL_STATS_EN adds run_cycles (watchdog count, frozen in DONE/TOUT).
module tb_sync_ctrl #(
  parameter int CHANNELS       = 4,
  parameter int HOLD_CYCLES    = 8,
  parameter int STAGGER        = 2,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 test_done,
  output logic [CHANNELS-1:0]  dut_reset,
  output logic                 run,
  output logic                 finished,
`ifdef TB_SYNC_CTRL_STATS_EN
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] run_cycles
`else
  output logic                 timeout
`endif
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam int                   LAST_REL = HOLD_CYCLES + (CHANNELS - 1) * STAGGER;
  localparam logic [CNT_WIDTH-1:0] HOLD_END = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_END = CNT_WIDTH'(LAST_REL - 1);
  localparam logic [CNT_WIDTH-1:0] TOUT_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);
  localparam bit                   DIRECT   = (STAGGER == 0) || (CHANNELS == 1);
  localparam bit                   WDOG_EN  = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_RELEASE, S_RUN, S_DONE, S_TOUT
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] seq_cnt, seq_cnt_nxt, seq_inc;
  logic [CNT_WIDTH-1:0] wdog_cnt, wdog_cnt_nxt, wdog_inc;

  // seq_cnt holds edges elapsed since START; wdog_cnt holds edges spent in RUN
  assign seq_inc  = (seq_cnt  == CNT_MAX) ? seq_cnt  : seq_cnt  + CNT_WIDTH'(1);
  assign wdog_inc = (wdog_cnt == CNT_MAX) ? wdog_cnt : wdog_cnt + CNT_WIDTH'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      seq_cnt  <= '0;
      wdog_cnt <= '0;
    end else begin
      state    <= state_nxt;
      seq_cnt  <= seq_cnt_nxt;
      wdog_cnt <= wdog_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    seq_cnt_nxt  = seq_cnt;
    wdog_cnt_nxt = wdog_cnt;
    case (state)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start) begin
          state_nxt    = S_HOLD;
          seq_cnt_nxt  = '0;
          wdog_cnt_nxt = '0;
        end
      end
      S_HOLD: begin
        seq_cnt_nxt = seq_inc;
        if (seq_cnt == HOLD_END) state_nxt = DIRECT ? S_RUN : S_RELEASE;
      end
      S_RELEASE: begin
        seq_cnt_nxt = seq_inc;
        if (seq_cnt == LAST_END) state_nxt = S_RUN;
      end
      S_RUN: begin
        wdog_cnt_nxt = wdog_inc;
        // completion wins over a watchdog expiry on the same edge
        if (test_done)                           state_nxt = S_DONE;
        else if (WDOG_EN && wdog_inc == TOUT_LIM) state_nxt = S_TOUT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    dut_reset = '1;
    case (state)
      S_RELEASE: begin
        for (int i = 0; i < CHANNELS; i++)
          dut_reset[i] = (seq_cnt < CNT_WIDTH'(HOLD_CYCLES + i * STAGGER));
      end
      S_RUN, S_DONE: dut_reset = '0;
      default: dut_reset = '1;
    endcase
  end

  assign run      = (state == S_RUN);
  assign finished = (state == S_DONE);
  assign timeout  = (state == S_TOUT);

`ifdef TB_SYNC_CTRL_STATS_EN
  assign run_cycles = wdog_cnt;
`endif

endmodule

// File: tb/tb_tb_sync_ctrl.sv
// tb/tb_tb_sync_ctrl.sv - randomized bench for tb_sync_ctrl against a timestamp-based model
// Four parameter sets share stimulus; each has its own reference state.
module tb_tb_sync_ctrl;

  localparam int NI = 4;
  localparam int P_C [NI] = '{4, 4, 8, 1};
  localparam int P_H [NI] = '{8, 8, 3, 5};
  localparam int P_S [NI] = '{2, 2, 0, 3};
  localparam int P_T [NI] = '{10000, 50, 0, 20};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic test_done = 1'b0;

  logic [3:0]  dr0, dr1;
  logic [7:0]  dr2;
  logic [0:0]  dr3;
  logic [NI-1:0] run_v, fin_v, to_v;
  logic [31:0] dr_act [NI];
  logic [31:0] rc_act [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef TB_SYNC_CTRL_STATS_EN
  logic [31:0] rc0, rc1, rc2, rc3;
  tb_sync_ctrl #(.CHANNELS(4), .HOLD_CYCLES(8), .STAGGER(2), .TIMEOUT_CYCLES(10000), .CNT_WIDTH(32)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .dut_reset(dr0),
    .run(run_v[0]), .finished(fin_v[0]), .timeout(to_v[0]), .run_cycles(rc0));
  tb_sync_ctrl #(.CHANNELS(4), .HOLD_CYCLES(8), .STAGGER(2), .TIMEOUT_CYCLES(50), .CNT_WIDTH(32)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .dut_reset(dr1),
    .run(run_v[1]), .finished(fin_v[1]), .timeout(to_v[1]), .run_cycles(rc1));
  tb_sync_ctrl #(.CHANNELS(8), .HOLD_CYCLES(3), .STAGGER(0), .TIMEOUT_CYCLES(0), .CNT_WIDTH(32)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .dut_reset(dr2),
    .run(run_v[2]), .finished(fin_v[2]), .timeout(to_v[2]), .run_cycles(rc2));
  tb_sync_ctrl #(.CHANNELS(1), .HOLD_CYCLES(5), .STAGGER(3), .TIMEOUT_CYCLES(20), .CNT_WIDTH(32)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .dut_reset(dr3),
    .run(run_v[3]), .finished(fin_v[3]), .timeout(to_v[3]), .run_cycles(rc3));
  assign rc_act[0] = rc0;
  assign rc_act[1] = rc1;
  assign rc_act[2] = rc2;
  assign rc_act[3] = rc3;
`else
  tb_sync_ctrl #(.CHANNELS(4), .HOLD_CYCLES(8), .STAGGER(2), .TIMEOUT_CYCLES(10000), .CNT_WIDTH(32)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .dut_reset(dr0),
    .run(run_v[0]), .finished(fin_v[0]), .timeout(to_v[0]));
  tb_sync_ctrl #(.CHANNELS(4), .HOLD_CYCLES(8), .STAGGER(2), .TIMEOUT_CYCLES(50), .CNT_WIDTH(32)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .dut_reset(dr1),
    .run(run_v[1]), .finished(fin_v[1]), .timeout(to_v[1]));
  tb_sync_ctrl #(.CHANNELS(8), .HOLD_CYCLES(3), .STAGGER(0), .TIMEOUT_CYCLES(0), .CNT_WIDTH(32)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .dut_reset(dr2),
    .run(run_v[2]), .finished(fin_v[2]), .timeout(to_v[2]));
  tb_sync_ctrl #(.CHANNELS(1), .HOLD_CYCLES(5), .STAGGER(3), .TIMEOUT_CYCLES(20), .CNT_WIDTH(32)) u3 (
    .clk(clk), .rst_n(rst_n), .start(start), .test_done(test_done), .dut_reset(dr3),
    .run(run_v[3]), .finished(fin_v[3]), .timeout(to_v[3]));
  always_comb for (int i = 0; i < NI; i++) rc_act[i] = 32'd0;
`endif

  assign dr_act[0] = {28'd0, dr0};
  assign dr_act[1] = {28'd0, dr1};
  assign dr_act[2] = {24'd0, dr2};
  assign dr_act[3] = {31'd0, dr3};

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endtask

  // Model: a sequence is a START timestamp plus an optional end (1 = done, 2 = watchdog)
  int n = 0;
  bit m_act [NI] = '{default: 1'b0};
  int m_start [NI] = '{default: 0};
  int m_end [NI] = '{default: 0};
  int m_rc [NI] = '{default: 0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        m_act[i] = 1'b0;
        m_end[i] = 0;
        m_rc[i]  = 0;
      end
    end else begin
      n = n + 1;
      for (int i = 0; i < NI; i++) begin
        int rel, el;
        rel = P_H[i] + (P_C[i] - 1) * P_S[i];
        if (!m_act[i] || m_end[i] != 0) begin
          if (start) begin
            m_act[i] = 1'b1; m_start[i] = n; m_end[i] = 0; m_rc[i] = 0;
          end
        end else begin
          el = n - m_start[i];
          if (el - 1 >= rel) begin
            if (test_done) begin
              m_end[i] = 1; m_rc[i] = el - rel;
            end else if (P_T[i] != 0 && el - rel == P_T[i]) begin
              m_end[i] = 2; m_rc[i] = el - rel;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic [31:0] ones, e_dr, e_rc;
      logic e_run, e_fin, e_to;
      int rel, el;
      ones = (P_C[i] == 32) ? 32'hffff_ffff : ((32'd1 << P_C[i]) - 32'd1);
      rel = P_H[i] + (P_C[i] - 1) * P_S[i];
      el = n - m_start[i];
      e_dr = ones; e_run = 1'b0; e_fin = 1'b0; e_to = 1'b0; e_rc = 32'd0;
      if (m_act[i]) begin
        if (m_end[i] == 1) begin
          e_dr = 32'd0; e_fin = 1'b1; e_rc = 32'(m_rc[i]);
        end else if (m_end[i] == 2) begin
          e_to = 1'b1; e_rc = 32'(m_rc[i]);
        end else begin
          for (int c = 0; c < P_C[i]; c++) e_dr[c] = (el < P_H[i] + c * P_S[i]);
          e_run = (el >= rel);
          e_rc  = e_run ? 32'(el - rel) : 32'd0;
        end
      end
      check("dut_reset", i, dr_act[i], e_dr);
      check("run", i, 32'(run_v[i]), 32'(e_run));
      check("finished", i, 32'(fin_v[i]), 32'(e_fin));
      check("timeout", i, 32'(to_v[i]), 32'(e_to));
`ifdef TB_SYNC_CTRL_STATS_EN
      check("run_cycles", i, rc_act[i], e_rc);
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    check("rst_dr0", 0, dr_act[0], 32'hf);
    check("rst_dr2", 2, dr_act[2], 32'hff);
    check("rst_run0", 0, 32'(run_v[0]), 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // First sequence: stagger timing, watchdog, restart from TOUT, completion at RUN cycle 100
    start = 1'b1;
    tick();
    start = 1'b0;
    check("hold_dr0", 0, dr_act[0], 32'hf);
    for (int e = 1; e <= 120; e++) begin
      tick();
      case (e)
        2:   check("s0_dr2_hold", 2, dr_act[2], 32'hff);
        3:   begin check("s0_dr2_rel", 2, dr_act[2], 32'h0); check("s0_run2", 2, 32'(run_v[2]), 32'd1); end
        4:   check("c1_run3_pre", 3, 32'(run_v[3]), 32'd0);
        5:   check("c1_run3", 3, 32'(run_v[3]), 32'd1);
        7:   check("dr0_e7", 0, dr_act[0], 32'hf);
        8:   check("dr0_e8", 0, dr_act[0], 32'he);
        10:  check("dr0_e10", 0, dr_act[0], 32'hc);
        12:  check("dr0_e12", 0, dr_act[0], 32'h8);
        13:  check("run0_e13", 0, 32'(run_v[0]), 32'd0);
        14:  begin check("dr0_e14", 0, dr_act[0], 32'h0); check("run0_e14", 0, 32'(run_v[0]), 32'd1); end
        63:  check("to1_e63", 1, 32'(to_v[1]), 32'd0);
        64:  begin check("to1_e64", 1, 32'(to_v[1]), 32'd1); check("tout_dr1", 1, dr_act[1], 32'hf); end
        69:  begin check("to3_e69", 3, 32'(to_v[3]), 32'd1); start = 1'b1; end
        70:  begin
               start = 1'b0;
               check("to3_clear", 3, 32'(to_v[3]), 32'd0);
               check("tout_hold_dr3", 3, dr_act[3], 32'h1);
               check("run2_ignore", 2, 32'(run_v[2]), 32'd1);
               check("run0_ignore", 0, 32'(run_v[0]), 32'd1);
             end
        113: test_done = 1'b1;
        114: begin
               test_done = 1'b0;
               check("fin0", 0, 32'(fin_v[0]), 32'd1);
               check("done_run0", 0, 32'(run_v[0]), 32'd0);
               check("done_dr0", 0, dr_act[0], 32'h0);
`ifdef TB_SYNC_CTRL_STATS_EN
               check("rc0_100", 0, rc_act[0], 32'd100);
`endif
             end
        default: ;
      endcase
    end

    // Reset during RELEASE, then replay
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 11; e++) tick();
    check("rel_dr0", 0, dr_act[0], 32'hc);
    rst_n = 1'b0;
    #1;
    check("async_dr0", 0, dr_act[0], 32'hf);
    check("async_run2", 2, 32'(run_v[2]), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("idle_dr0", 0, dr_act[0], 32'hf);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int e = 1; e <= 66; e++) begin
      tick();
      case (e)
        8:  check("r_dr0_e8", 0, dr_act[0], 32'he);
        14: check("r_run0_e14", 0, 32'(run_v[0]), 32'd1);
        63: test_done = 1'b1;
        64: begin
              test_done = 1'b0;
              check("tie_fin1", 1, 32'(fin_v[1]), 32'd1);
              check("tie_to1", 1, 32'(to_v[1]), 32'd0);
            end
        default: ;
      endcase
    end

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
      start     = ($urandom_range(0, 29) == 0);
      test_done = ($urandom_range(0, 39) == 0);
    end
    start = 1'b0;
    test_done = 1'b0;
    rst_n = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tb_sync_ctrl.md
TB_SYNC_CTRL -- requirements
Module: tb_sync_ctrl

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent DUT reset outputs; legal range 1..32.
REQ-002 Parameter HOLD_CYCLES, default 8: cycles all channel resets stay asserted after START; legal range 1..65535.
REQ-003 Parameter STAGGER, default 2: cycles between release of consecutive channels; 0 releases all channels together.
REQ-004 Parameter TIMEOUT_CYCLES, default 10000: watchdog limit in RUN; 0 disables the watchdog.
REQ-005 Parameter CNT_WIDTH, default 32: width of internal counters and RUN_CYCLES.
REQ-006 CLK  input  1  single clock; all logic on rising edge.
REQ-007 RESET  input  1  asynchronous, active-low reset.
REQ-008 START  input  1  begin a reset/run sequence; sampled only in IDLE, DONE and TIMEOUT.
REQ-009 TEST_DONE  input  1  test completion indication; sampled only in RUN.
REQ-010 DUT_RESET  output  CHANNELS  per-channel active-high DUT reset, bit i = channel i.
REQ-011 RUN  output  1  high while all channels are released and the test is running.
REQ-012 FINISHED  output  1  sticky: test ended by TEST_DONE.
REQ-013 TIMEOUT  output  1  sticky: watchdog expired.

Function
REQ-014 The block SHALL implement FSM states IDLE, HOLD, RELEASE, RUN, DONE, TOUT.
REQ-015 START high at edge k in IDLE/DONE/TOUT SHALL enter HOLD, clear FINISHED, TIMEOUT and both counters, and drive DUT_RESET all ones.
REQ-016 Channel i SHALL deassert DUT_RESET[i] at edge k+HOLD_CYCLES+i*STAGGER and keep it low until RUN ends.
REQ-017 HOLD SHALL move to RELEASE at edge k+HOLD_CYCLES; RELEASE SHALL move to RUN on the same edge the last channel is released.
REQ-018 RUN SHALL be high exactly in state RUN; FINISHED exactly in DONE; TIMEOUT exactly in TOUT.
REQ-019 With STAGGER=0 or CHANNELS=1, RELEASE SHALL last zero cycles (HOLD goes directly to RUN at edge k+HOLD_CYCLES).
REQ-020 In RUN the watchdog counter SHALL increment every cycle from 0; TEST_DONE high SHALL move to DONE on the next edge.
REQ-021 If the watchdog count reaches TIMEOUT_CYCLES (nonzero) in RUN, the FSM SHALL move to TOUT and drive DUT_RESET all ones.
REQ-022 TEST_DONE and watchdog expiry on the same edge SHALL resolve to DONE.
REQ-023 In DONE, DUT_RESET SHALL remain all zeros; in TOUT, all ones.
REQ-024 START in HOLD, RELEASE or RUN SHALL be ignored; TEST_DONE outside RUN SHALL be ignored.
REQ-025 Counters SHALL saturate at 2^CNT_WIDTH-1 and never wrap.

Reset
REQ-026 RESET low SHALL immediately, without a clock edge, force state IDLE, DUT_RESET all ones, RUN=0, FINISHED=0, TIMEOUT=0, and counters 0.
REQ-027 RESET asserted mid-sequence (any state) SHALL abort it; after release the block SHALL wait in IDLE for START.

Configuration
REQ-028 Macro TB_SYNC_CTRL_STATS_EN defined SHALL add output RUN_CYCLES [CNT_WIDTH] holding the watchdog count, frozen on entry to DONE/TOUT, cleared on START and reset.
REQ-029 Without TB_SYNC_CTRL_STATS_EN, RUN_CYCLES and its freeze logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-030 Defaults; START at edge 10 -> DUT_RESET[0] falls at 18, [1] at 20, [2] at 22, [3] at 24; RUN rises at 24.
REQ-031 Defaults; TEST_DONE at RUN cycle 100 -> FINISHED=1, RUN=0, DUT_RESET=0000; RUN_CYCLES=100 with STATS_EN.
REQ-032 TIMEOUT_CYCLES=50, no TEST_DONE -> TIMEOUT=1 at 50 cycles after RUN rises; DUT_RESET=1111; TEST_DONE on that same edge instead yields FINISHED=1, TIMEOUT=0.
REQ-033 RESET pulsed low during RELEASE after channel 1 released -> DUT_RESET=1111 asynchronously, state IDLE; a subsequent START replays the REQ-030 timing.
REQ-034 STAGGER=0, CHANNELS=8, HOLD_CYCLES=3 -> all eight bits fall together 3 edges after START; START pulses during RUN have no effect.
REQ-035 From TOUT, START -> TIMEOUT clears on the next edge and the HOLD sequence restarts; with TIMEOUT_CYCLES=0 RUN persists for 100000 cycles without TIMEOUT.
